// File: rtl/seq_detector_moore.sv
// -----------------------------------------------------------------------------
// seq_detector_moore
//
// Moore-type serial pattern detector for single-bit streams. One bit is
// consumed on every clock edge with en=1. The state register holds the
// length of the longest pattern prefix that is currently matched (0..N).
// The match flag y is high exactly while that length equals N. A saturating
// counter records the number of completed matches.
//
// Parameters
//   N        pattern length in bits, 1..16
//   PATTERN  target sequence; PATTERN[N-1] is expected first, PATTERN[0] last
//   OVERLAP  1: matches may share bits; 0: restart from empty after a match
//   CNT_W    width of match_count
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   en           in   sample strobe; x is consumed only when en=1
//   x            in   serial data bit
//   clr_count    in   synchronous clear of match_count (beats an increment)
//   y            out  registered match flag (state == N)
//   match_count  out  registered saturating match counter
// -----------------------------------------------------------------------------
module seq_detector_moore #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr_count,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  // Reject unsupported configurations while elaborating.
  if (N < 1 || N > 16) begin : g_bad_n
    $fatal(1, "seq_detector_moore: N must be in the range 1..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "seq_detector_moore: CNT_W must be at least 1");
  end

  localparam int SW = (N < 1) ? 1 : $clog2(N + 1);

  typedef logic [SW-1:0] state_t;

  localparam state_t             S_EMPTY = '0;
  localparam state_t             S_FULL  = SW'(N);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  // KMP-style transition. The k matched bits are always the first k bits of
  // PATTERN, so the sequence "matched bits followed by b" can be rebuilt from
  // the parameter alone: shift the pattern prefix up by one and append b.
  // The result is the longest j such that the last j bits of that sequence
  // equal the first j pattern bits. Everything except k and b is constant,
  // so this folds into a small lookup after synthesis. States above N are
  // unreachable but are treated like N so a corrupted state still recovers.
  function automatic state_t next_state_f(input state_t k_in, input logic b);
    logic [31:0] pat;
    logic [31:0] seq;
    logic [31:0] mask;
    logic [31:0] pre;
    int          k;
    int          best;
    pat  = 32'(PATTERN);
    k    = int'(k_in);
    if (k >= N) begin
      k = OVERLAP ? N : 0;
    end else begin
      k = k;
    end
    seq  = ((pat >> (N - k)) << 1) | 32'(b);
    best = 0;
    for (int j = 1; j <= 16; j++) begin
      if (j <= N && j <= k + 1) begin
        mask = (32'd1 << j) - 32'd1;
        pre  = pat >> (N - j);
        best = ((seq & mask) == pre) ? j : best;
      end else begin
        best = best;
      end
    end
    return SW'(best);
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic             y_q;
  logic             y_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit_s;

  // Next-state, match flag and counter update.
  always_comb begin
    state_d = state_q;
    hit_s   = 1'b0;
    cnt_d   = cnt_q;
    if (en) begin
      state_d = next_state_f(state_q, x);
    end else begin
      state_d = state_q;
    end
    hit_s = en & (state_d == S_FULL);
    y_d   = (state_d == S_FULL);
    if (clr_count) begin
      cnt_d = '0;
    end else if (hit_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, flag and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      y_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y           = y_q;
  assign match_count = cnt_q;

endmodule
